// File: rtl/dma_bus_arbiter_if.sv
// Bus-ownership handshake between the Amiga-side DMA master, the 68030 and the arbiter.
// All strobes and grants are active low; BUSOWN and DMA_ACTIVE are active high.
interface dma_bus_arbiter_if;
  logic BR20;
  logic BGACK20;
  logic AS20;
  logic AS30;
  logic BG30;
  logic BR30;
  logic BGACK30;
  logic BG20;
  logic BUSOWN;
  logic DMA_ACTIVE;

  modport master (
    input  BR20, BGACK20, AS20, AS30, BG30,
    output BR30, BGACK30, BG20, BUSOWN, DMA_ACTIVE
  );

  modport slave (
    output BR20, BGACK20, AS20, AS30, BG30,
    input  BR30, BGACK30, BG20, BUSOWN, DMA_ACTIVE
  );
endinterface

// File: rtl/dma_bus_arbiter.sv
// Hands the Amiga-side bus between the 68030 path and Amiga DMA masters (BR/BG/BGACK translation).
// Optional feature macro DMA_HOLDOFF_EN: stretches RELEASE to HOLDOFF_CYCLES cycles (minimum 1).
//
// state     | meaning
// S_IDLE    | 68030 side owns the bus, no request pending
// S_REQ     | DMA request seen, BR30 asserted, waiting for a quiet granted bus
// S_GRANT   | BG20 asserted, waiting for BGACK20 (bounded by GRANT_TIMEOUT)
// S_DMA     | DMA master holds the bus, BGACK30 asserted on its behalf
// S_RELEASE | handshake negated, bridge still tristated before returning to IDLE
module dma_bus_arbiter #(
  parameter int SYNC_STAGES    = 2,
  parameter int GRANT_TIMEOUT  = 31,
  parameter int HOLDOFF_CYCLES = 4
) (
  input logic         CLKCPU,
  input logic         RESET,
  dma_bus_arbiter_if.master bus
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("dma_bus_arbiter: SYNC_STAGES must be at least 2");
  end
  if (HOLDOFF_CYCLES < 0) begin : g_bad_holdoff
    $error("dma_bus_arbiter: HOLDOFF_CYCLES must not be negative");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_GRANT,
    S_DMA,
    S_RELEASE
  } state_t;

  localparam int CW = (GRANT_TIMEOUT < 1) ? 1 : $clog2(GRANT_TIMEOUT + 1);
  localparam logic [CW-1:0] GRANT_MAX  = CW'(GRANT_TIMEOUT);
  // grant_cnt holds GRANT cycles already spent, so the grant lasts GRANT_TIMEOUT cycles (at least one)
  localparam logic [CW-1:0] GRANT_LAST = CW'((GRANT_TIMEOUT < 1) ? 0 : GRANT_TIMEOUT - 1);

  state_t state;
  state_t state_nxt;

  logic [SYNC_STAGES-1:0] br20_sync;
  logic [SYNC_STAGES-1:0] bgack20_sync;
  logic [SYNC_STAGES-1:0] as20_sync;
  logic                   br20_s;
  logic                   bgack20_s;
  logic                   as20_s;

  logic [CW-1:0] grant_cnt;
  logic          grant_expired;
  logic          release_done;

  logic br30_q;
  logic bgack30_q;
  logic bg20_q;
  logic busown_q;
  logic dma_active_q;

  assign br20_s        = br20_sync[SYNC_STAGES-1];
  assign bgack20_s     = bgack20_sync[SYNC_STAGES-1];
  assign as20_s        = as20_sync[SYNC_STAGES-1];
  assign grant_expired = (grant_cnt >= GRANT_LAST);

`ifdef DMA_HOLDOFF_EN
  localparam int HOLD_LEN = (HOLDOFF_CYCLES < 1) ? 1 : HOLDOFF_CYCLES;
  localparam int HW       = (HOLD_LEN < 2) ? 1 : $clog2(HOLD_LEN);

  // Down-counter loaded on RELEASE entry; zero marks the last dwell cycle.
  logic [HW-1:0] hold_cnt;

  assign release_done = (hold_cnt == '0);

  always_ff @(posedge CLKCPU or negedge RESET) begin
    if (!RESET) begin
      hold_cnt <= '0;
    end else if (state_nxt == S_RELEASE && state != S_RELEASE) begin
      hold_cnt <= HW'(HOLD_LEN - 1);
    end else if (state == S_RELEASE && hold_cnt != '0) begin
      hold_cnt <= hold_cnt - 1'b1;
    end
  end
`else
  assign release_done = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (!br20_s) state_nxt = S_REQ;
      end
      S_REQ: begin
        if (br20_s)                               state_nxt = S_IDLE;
        else if (!bus.BG30 && bus.AS30 && as20_s) state_nxt = S_GRANT;
      end
      S_GRANT: begin
        if (!bgack20_s && as20_s) state_nxt = S_DMA;
        else if (br20_s)          state_nxt = S_RELEASE;
        else if (grant_expired)   state_nxt = S_RELEASE;
      end
      S_DMA: begin
        if (bgack20_s) state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        if (release_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge CLKCPU or negedge RESET) begin
    if (!RESET) begin
      state        <= S_IDLE;
      br20_sync    <= '1;
      bgack20_sync <= '1;
      as20_sync    <= '1;
      grant_cnt    <= '0;
      br30_q       <= 1'b1;
      bgack30_q    <= 1'b1;
      bg20_q       <= 1'b1;
      busown_q     <= 1'b1;
      dma_active_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      br20_sync    <= {br20_sync[SYNC_STAGES-2:0], bus.BR20};
      bgack20_sync <= {bgack20_sync[SYNC_STAGES-2:0], bus.BGACK20};
      as20_sync    <= {as20_sync[SYNC_STAGES-2:0], bus.AS20};

      if (state != S_GRANT)            grant_cnt <= '0;
      else if (grant_cnt != GRANT_MAX) grant_cnt <= grant_cnt + 1'b1;

      br30_q       <= 1'b1;
      bgack30_q    <= 1'b1;
      bg20_q       <= 1'b1;
      busown_q     <= 1'b1;
      dma_active_q <= 1'b0;
      case (state_nxt)
        S_REQ: begin
          br30_q <= 1'b0;
        end
        S_GRANT: begin
          br30_q   <= 1'b0;
          bg20_q   <= 1'b0;
          busown_q <= 1'b0;
        end
        S_DMA: begin
          bgack30_q    <= 1'b0;
          busown_q     <= 1'b0;
          dma_active_q <= 1'b1;
        end
        S_RELEASE: begin
          busown_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.BR30       = br30_q;
  assign bus.BGACK30    = bgack30_q;
  assign bus.BG20       = bg20_q;
  assign bus.BUSOWN     = busown_q;
  assign bus.DMA_ACTIVE = dma_active_q;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed and randomized bench for dma_bus_arbiter, honouring DMA_HOLDOFF_EN if defined.
module tb_dma_bus_arbiter;
  localparam int SYNC = 2;
  localparam int GT   = 31;
  localparam int HO   = 4;
  localparam int GRANT_LEN = (GT < 1) ? 1 : GT;
`ifdef DMA_HOLDOFF_EN
  localparam int REL_LEN = (HO < 1) ? 1 : HO;
`else
  localparam int REL_LEN = 1;
`endif

  // Output vectors {BR30, BGACK30, BG20, BUSOWN, DMA_ACTIVE}
  localparam logic [4:0] IDLE_O  = 5'b11110;
  localparam logic [4:0] REQ_O   = 5'b01110;
  localparam logic [4:0] GRANT_O = 5'b01000;
  localparam logic [4:0] DMA_O   = 5'b10101;
  localparam logic [4:0] REL_O   = 5'b11100;

  logic CLKCPU = 1'b0;
  logic RESET;
  dma_bus_arbiter_if bus();

  dma_bus_arbiter #(
    .SYNC_STAGES   (SYNC),
    .GRANT_TIMEOUT (GT),
    .HOLDOFF_CYCLES(HO)
  ) dut (
    .CLKCPU(CLKCPU),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLKCPU = ~CLKCPU;

  int errors = 0;
  int checks = 0;

  function automatic logic [4:0] outs();
    return {bus.BR30, bus.BGACK30, bus.BG20, bus.BUSOWN, bus.DMA_ACTIVE};
  endfunction

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLKCPU);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Counts consecutive cycles showing pat, starting with the current one (bounded).
  task automatic count_run(input logic [4:0] pat, output int n);
    n = 0;
    while (outs() === pat && n < 200) begin
      n++;
      tick();
    end
  endtask

  // Reference model: abstract phase plus cycle counts; synchronisers as delay queues.
  typedef enum int {M_IDLE, M_REQ, M_GRANT, M_DMA, M_REL} mphase_t;
  mphase_t m_ph;
  int      m_grant_cycles;
  int      m_rel_cycles;
  logic    brq[$];
  logic    bgq[$];
  logic    asq[$];

  task automatic model_reset();
    m_ph = M_IDLE;
    m_grant_cycles = 0;
    m_rel_cycles = 0;
    brq.delete(); bgq.delete(); asq.delete();
    for (int i = 0; i < SYNC; i++) begin
      brq.push_back(1'b1); bgq.push_back(1'b1); asq.push_back(1'b1);
    end
  endtask

  task automatic model_edge();
    logic br_s, bg_s, as_s;
    br_s = brq.pop_front(); brq.push_back(bus.BR20);
    bg_s = bgq.pop_front(); bgq.push_back(bus.BGACK20);
    as_s = asq.pop_front(); asq.push_back(bus.AS20);
    case (m_ph)
      M_IDLE: if (!br_s) m_ph = M_REQ;
      M_REQ: begin
        if (br_s) m_ph = M_IDLE;
        else if (!bus.BG30 && bus.AS30 && as_s) begin
          m_ph = M_GRANT;
          m_grant_cycles = 0;
        end
      end
      M_GRANT: begin
        m_grant_cycles++;
        if (!bg_s && as_s) m_ph = M_DMA;
        else if (br_s || m_grant_cycles >= GRANT_LEN) begin
          m_ph = M_REL;
          m_rel_cycles = 0;
        end
      end
      M_DMA: if (bg_s) begin
        m_ph = M_REL;
        m_rel_cycles = 0;
      end
      M_REL: begin
        m_rel_cycles++;
        if (m_rel_cycles >= REL_LEN) m_ph = M_IDLE;
      end
      default: m_ph = M_IDLE;
    endcase
  endtask

  function automatic logic [4:0] model_outs();
    case (m_ph)
      M_REQ:   return REQ_O;
      M_GRANT: return GRANT_O;
      M_DMA:   return DMA_O;
      M_REL:   return REL_O;
      default: return IDLE_O;
    endcase
  endfunction

  initial begin
    int n;
    bus.BR20 = 1'b1; bus.BGACK20 = 1'b1; bus.AS20 = 1'b1;
    bus.AS30 = 1'b1; bus.BG30 = 1'b1;
    RESET = 1'b0;
    #12;
    chk("reset_state", outs(), IDLE_O);
    tick();
    RESET = 1'b1;

    // 1: quiet bus after reset
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_quiet", outs(), IDLE_O);
    end

    // 2: full tenure
    bus.BR20 = 1'b0;
    ticks(2);
    chk("br30_not_yet", outs(), IDLE_O);
    tick();
    chk("br30_latency", outs(), REQ_O);
    bus.BG30 = 1'b0;
    tick();
    chk("bg20_latency", outs(), GRANT_O);
    bus.BGACK20 = 1'b0;
    ticks(2);
    chk("bgack_not_yet", outs(), GRANT_O);
    tick();
    chk("dma_entry", outs(), DMA_O);
    bus.BR20 = 1'b1; bus.BG30 = 1'b1; bus.BGACK20 = 1'b1;
    ticks(2);
    chk("dma_hold", outs(), DMA_O);
    tick();
    chk("release_entry", outs(), REL_O);
    count_run(REL_O, n);
    chk_int("release_len", n, REL_LEN);
    chk("busown_back", outs(), IDLE_O);

    // 3: 68030 cycle in progress blocks the grant
    bus.BR20 = 1'b0;
    ticks(3);
    chk("req_again", outs(), REQ_O);
    bus.AS30 = 1'b0; bus.BG30 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("as30_blocks", outs(), REQ_O);
    end
    bus.AS30 = 1'b1;
    tick();
    chk("as30_free_grant", outs(), GRANT_O);
    bus.BR20 = 1'b1; bus.BG30 = 1'b1;
    ticks(2);
    chk("grant_hold", outs(), GRANT_O);
    tick();
    chk("withdraw_release", outs(), REL_O);
    count_run(REL_O, n);
    chk("withdraw_idle", outs(), IDLE_O);

    // 4: grant timeout
    bus.BR20 = 1'b0;
    ticks(3);
    chk("req_timeout", outs(), REQ_O);
    bus.BG30 = 1'b0;
    tick();
    count_run(GRANT_O, n);
    bus.BG30 = 1'b1;
    chk_int("grant_timeout_len", n, GRANT_LEN);
    chk("timeout_release", outs(), REL_O);
    count_run(REL_O, n);
    chk_int("timeout_rel_len", n, REL_LEN);
    chk("timeout_busown", outs(), IDLE_O);
    tick();
    chk("timeout_rereq", outs(), REQ_O);

    // 5: withdrawal in the same cycle the 68030 grants
    bus.BR20 = 1'b1;
    ticks(2);
    chk("withdraw_pending", outs(), REQ_O);
    bus.BG30 = 1'b0;
    tick();
    chk("withdraw_priority", outs(), IDLE_O);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_bg20", outs(), IDLE_O);
    end
    bus.BG30 = 1'b1;

    // back-to-back tenures: the release dwell between them
    bus.BR20 = 1'b0;
    ticks(3);
    bus.BG30 = 1'b0;
    tick();
    bus.BGACK20 = 1'b0;
    ticks(3);
    chk("b2b_dma", outs(), DMA_O);
    bus.BGACK20 = 1'b1;
    ticks(3);
    count_run(REL_O, n);
    chk_int("b2b_release_len", n, REL_LEN);
    chk("b2b_idle", outs(), IDLE_O);
    tick();
    chk("b2b_rereq", outs(), REQ_O);
    tick();
    chk("b2b_regrant", outs(), GRANT_O);

    // 6: asynchronous reset mid-DMA
    bus.BGACK20 = 1'b0;
    ticks(3);
    chk("pre_reset_dma", outs(), DMA_O);
    #2;
    RESET = 1'b0;
    #1;
    chk("async_reset", outs(), IDLE_O);
    bus.BR20 = 1'b1; bus.BGACK20 = 1'b1; bus.BG30 = 1'b1;
    tick();
    chk("reset_held", outs(), IDLE_O);
    RESET = 1'b1;
    model_reset();

    // Randomized phase against the reference model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(5) == 0) bus.BR20    = ~bus.BR20;
      if ($urandom_range(7) == 0) bus.BGACK20 = ~bus.BGACK20;
      if ($urandom_range(3) == 0) bus.AS20    = ~bus.AS20;
      if ($urandom_range(3) == 0) bus.AS30    = ~bus.AS30;
      if ($urandom_range(2) == 0) bus.BG30    = ~bus.BG30;
      @(posedge CLKCPU);
      model_edge();
      tick();
      chk("random_model", outs(), model_outs());
      if (bus.BG20 === 1'b0 && bus.BGACK30 === 1'b0)
        chk("bg20_bgack30_excl", {bus.BG20, bus.BGACK30}, 2'b11);
      if (bus.BUSOWN === 1'b1 && (bus.BG20 === 1'b0 || bus.BGACK30 === 1'b0))
        chk("busown_excl", {4'b0, bus.BUSOWN}, 5'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
